// File: rtl/line_buffer_array.sv
// -----------------------------------------------------------------------------
// line_buffer_array
//
// Purpose:
//   Streaming line buffer for 2-D window filters. Pixels arrive in raster
//   order; KSIZE-1 line stores keep the previous rows so that every incoming
//   pixel can be presented together with the pixels directly above it as one
//   vertical column of KSIZE pixels.
//
// Parameters:
//   WIDTH      bits per pixel
//   IMG_WIDTH  pixels per image row (2 .. 2**CNT_W)
//   KSIZE      rows per output column (2 .. 7)
//   CNT_W      width of the column counter / col_idx
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   frame_start  synchronous pulse, restarts row/column counting
//   din          incoming pixel
//   valid_in     din is valid this cycle
//   dout         column of pixels; slice k (k*WIDTH +: WIDTH) is the pixel
//                k rows above the current one, slice 0 is the current pixel
//   valid_out    dout holds a complete column
//   col_idx      column index of the pixel in dout
//   row_full     KSIZE-1 complete rows are stored
//   line_end     one-cycle pulse with the valid output of the last column
// -----------------------------------------------------------------------------
module line_buffer_array #(
  parameter int WIDTH     = 8,
  parameter int IMG_WIDTH = 482,
  parameter int KSIZE     = 3,
  parameter int CNT_W     = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic [WIDTH-1:0]       din,
  input  logic                   valid_in,
  output logic [KSIZE*WIDTH-1:0] dout,
  output logic                   valid_out,
  output logic [CNT_W-1:0]       col_idx,
  output logic                   row_full,
  output logic                   line_end
);

  // Address width of one line store; only the low bits of the column
  // counter are needed to index it.
  localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  // Row counter saturates at KSIZE-1 <= 6, so three bits always suffice.
  localparam int ROW_W = 3;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(KSIZE - 1);

  // Reject illegal configurations at elaboration time.
  if (KSIZE < 2 || KSIZE > 7) begin : g_bad_ksize
    $error("line_buffer_array: KSIZE must be in 2..7");
  end
  if (IMG_WIDTH < 2 || IMG_WIDTH > (1 << CNT_W)) begin : g_bad_width
    $error("line_buffer_array: IMG_WIDTH must be in 2..2**CNT_W");
  end

  // Line store k holds the row that is k+1 rows above the incoming one.
  logic [WIDTH-1:0] line_mem [KSIZE-1][IMG_WIDTH];

  logic [CNT_W-1:0]       col;
  logic [ROW_W-1:0]       row_cnt;
  logic [CNT_W-1:0]       cur_col;
  logic [ROW_W-1:0]       cur_row;
  logic [ADDR_W-1:0]      addr;
  logic                   col_wrap;
  logic                   row_done;
  logic [KSIZE*WIDTH-1:0] column;

  // A frame_start in the same cycle as a pixel makes that pixel column 0 of
  // row 0, so the effective position is selected before anything else.
  always_comb begin
    cur_col  = frame_start ? '0 : col;
    cur_row  = frame_start ? '0 : row_cnt;
    addr     = cur_col[ADDR_W-1:0];
    col_wrap = (cur_col == LAST_COL);
    row_done = (cur_row == ROW_MAX);
  end

  // Assemble the output column from the current pixel and the pre-write
  // contents of every line store at the current column.
  always_comb begin
    column = '0;
    column[WIDTH-1:0] = din;
    for (int k = 1; k < KSIZE; k++) begin
      column[k*WIDTH +: WIDTH] = line_mem[k-1][addr];
    end
  end

  // Line stores shift down by one row at the current column. Non-blocking
  // assignments make each store take the old value of the one above it.
  // No reset: the contents are don't-care until a full set of rows is in.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      line_mem[0][addr] <= din;
      for (int k = 1; k < KSIZE - 1; k++) begin
        line_mem[k][addr] <= line_mem[k-1][addr];
      end
    end
  end

  // Position counters and registered outputs. The row counter is compared
  // before it increments, so the wrap that fills the last row only enables
  // valid_out from the following pixel on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row_cnt   <= '0;
      dout      <= '0;
      col_idx   <= '0;
      valid_out <= 1'b0;
      line_end  <= 1'b0;
    end else if (valid_in) begin
      col       <= col_wrap ? '0 : cur_col + 1'b1;
      row_cnt   <= (col_wrap && !row_done) ? cur_row + 1'b1 : cur_row;
      dout      <= column;
      col_idx   <= cur_col;
      valid_out <= row_done && !frame_start;
      line_end  <= row_done && !frame_start && col_wrap;
    end else begin
      col       <= cur_col;
      row_cnt   <= cur_row;
      valid_out <= 1'b0;
      line_end  <= 1'b0;
    end
  end

  assign row_full = (row_cnt == ROW_MAX);

endmodule

// File: doc/line_buffer_array.md
LINE_BUFFER_ARRAY -- requirements
Module: line_buffer_array

Interface
REQ-001 Parameter WIDTH, default 8, bits per pixel.
REQ-002 Parameter IMG_WIDTH, default 482, pixels per image row (legal range 2..2^CNT_W).
REQ-003 Parameter KSIZE, default 3, rows presented per output column (legal range 2..7).
REQ-004 Parameter CNT_W, default 9, column counter width.
REQ-005 Port clk, input, 1, single clock; all logic on rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port frame_start, input, 1, synchronous pulse that restarts row/column counting for a new frame.
REQ-008 Port din, input, WIDTH, incoming pixel in raster order.
REQ-009 Port valid_in, input, 1, din is valid this cycle.
REQ-010 Port dout, output, KSIZE*WIDTH, vertical pixel column: slice k (bits k*WIDTH+:WIDTH) is the pixel k rows above the current pixel; slice 0 is the current pixel.
REQ-011 Port valid_out, output, 1, dout holds a complete column.
REQ-012 Port col_idx, output, CNT_W, column index of the pixel in dout.
REQ-013 Port row_full, output, 1, high once KSIZE-1 complete rows are stored.
REQ-014 Port line_end, output, 1, one-cycle pulse aligned with valid output of column IMG_WIDTH-1.

Function
REQ-015 The block SHALL hold KSIZE-1 line stores of IMG_WIDTH x WIDTH each, implemented in inferred RAM/registers with no vendor FIFO IP.
REQ-016 All line stores SHALL share one column pointer col (0..IMG_WIDTH-1); on valid_in it advances by 1 and wraps from IMG_WIDTH-1 to 0.
REQ-017 On each valid_in cycle at column c, line store 0 SHALL be written with din and line store k (k>=1) with the pre-write content of line store k-1 at c.
REQ-018 dout SHALL be registered with 1-cycle latency: slice 0 = din, slice k = pre-write content of line store k-1 at c.
REQ-019 A row counter SHALL increment on each column wrap and saturate at KSIZE-1; row_full = (row counter == KSIZE-1).
REQ-020 valid_out SHALL be asserted one cycle after a valid_in cycle that occurs while row_full is high (including the wrap cycle that sets it only from the next pixel on), else deasserted.
REQ-021 col_idx and line_end SHALL be registered alongside dout; line_end = valid_out and col_idx == IMG_WIDTH-1.
REQ-022 When valid_in is low, col, row counter and line stores SHALL hold; valid_out and line_end SHALL be 0; dout and col_idx SHALL hold their last values.
REQ-023 frame_start SHALL clear col and the row counter to 0 (line store contents are not cleared) and force valid_out to 0 next cycle.
REQ-024 frame_start with valid_in in the same cycle SHALL process din as column 0 of row 0 of the new frame, producing valid_out = 0.
REQ-025 Bubbles in valid_in of any length, including mid-row, SHALL not alter the output sequence other than by delaying it.

Reset
REQ-026 While rst_n is low, col, row counter, dout, col_idx, valid_out, line_end and row_full SHALL be 0; line store contents are undefined.
REQ-027 Reset asserted mid-frame SHALL take effect immediately; the first valid_in after release is column 0 of row 0.

Verification
REQ-028 WIDTH=8, IMG_WIDTH=4, KSIZE=3, continuous pixels 1..12 -> valid_out low for pixels 1..8; pixel 9 yields dout slices {0:9,1:5,2:1}, col_idx 0; pixel 12 yields {12,8,4}, col_idx 3, line_end 1.
REQ-029 Same stream with valid_in toggling every other cycle -> identical dout/col_idx sequence, valid_out never high on the cycle after an idle cycle.
REQ-030 frame_start pulsed after pixel 10, then pixels 21..29 -> row_full drops to 0, valid_out low for 21..28, pixel 29 yields {29,25,21}.
REQ-031 rst_n low after pixel 6 for 2 cycles -> all outputs 0 during reset; following pixels behave as a fresh frame (no valid_out before 9th pixel).
REQ-032 KSIZE=2, IMG_WIDTH=2, pixels 1..4 -> valid_out on pixels 3,4 with {3,1},{4,2}; line_end on pixel 4.
